// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter.
package data_mem_arbiter_pkg;

  localparam int DEF_NUM_CONSUMERS = 4;
  localparam int DEF_ADDR_BITS     = 8;
  localparam int DEF_DATA_BITS     = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ_WAIT  = 2'd1,
    ST_WRITE_WAIT = 2'd2,
    ST_RELAY      = 2'd3
  } arbiter_state_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first requesting channel at or after i_ptr.
module rr_picker #(
  parameter int NUM_CONSUMERS = 4,
  parameter int IDX_BITS      = 2
) (
  input  logic [NUM_CONSUMERS-1:0] i_req,
  input  logic [IDX_BITS-1:0]      i_ptr,
  output logic                     o_valid,
  output logic [IDX_BITS-1:0]      o_idx
);

  int w_cand;

  // Walk the rotated order backwards so the lowest rotation offset wins last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= NUM_CONSUMERS) begin
        w_cand = w_cand - NUM_CONSUMERS;
      end
      if (i_req[IDX_BITS'(w_cand)]) begin
        o_valid = 1'b1;
        o_idx   = IDX_BITS'(w_cand);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data memory port among several LSU channels, one transaction at a time.
//
// state         | meaning
// ST_IDLE       | no transaction; pick next channel round-robin from grant_ptr
// ST_READ_WAIT  | memory read issued, waiting for mem_read_ready
// ST_WRITE_WAIT | memory write issued, waiting for mem_write_ready
// ST_RELAY      | ready pulsed to owner; wait for owner to drop the served valid
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CONSUMERS-1:0]               consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]               consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]               consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]               consumer_write_ready,
  output logic                                   mem_read_valid,
  output logic [ADDR_BITS-1:0]                   mem_read_address,
  input  logic                                   mem_read_ready,
  input  logic [DATA_BITS-1:0]                   mem_read_data,
  output logic                                   mem_write_valid,
  output logic [ADDR_BITS-1:0]                   mem_write_address,
  output logic [DATA_BITS-1:0]                   mem_write_data,
  input  logic                                   mem_write_ready
);

  localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

  arbiter_state_t r_state, w_state_nxt;
  logic [IDX_BITS-1:0] r_grant_ptr, w_grant_ptr_nxt;
  logic [IDX_BITS-1:0] r_owner, w_owner_nxt;
  logic                r_served_read, w_served_read_nxt;
  logic                r_mem_rd_valid, w_mem_rd_valid_nxt;
  logic [ADDR_BITS-1:0] r_mem_rd_addr, w_mem_rd_addr_nxt;
  logic                r_mem_wr_valid, w_mem_wr_valid_nxt;
  logic [ADDR_BITS-1:0] r_mem_wr_addr, w_mem_wr_addr_nxt;
  logic [DATA_BITS-1:0] r_mem_wr_data, w_mem_wr_data_nxt;
  logic [NUM_CONSUMERS-1:0] r_cons_rd_ready, w_cons_rd_ready_nxt;
  logic [NUM_CONSUMERS-1:0] r_cons_wr_ready, w_cons_wr_ready_nxt;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_cons_rd_data, w_cons_rd_data_nxt;

  logic                w_pick_valid;
  logic [IDX_BITS-1:0] w_pick_idx;

  rr_picker #(
    .NUM_CONSUMERS (NUM_CONSUMERS),
    .IDX_BITS      (IDX_BITS)
  ) u_rr_picker (
    .i_req   (consumer_read_valid | consumer_write_valid),
    .i_ptr   (r_grant_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // Next-state and next-output decode; consumer readies default low so they only pulse.
  always_comb begin
    w_state_nxt         = r_state;
    w_grant_ptr_nxt     = r_grant_ptr;
    w_owner_nxt         = r_owner;
    w_served_read_nxt   = r_served_read;
    w_mem_rd_valid_nxt  = r_mem_rd_valid;
    w_mem_rd_addr_nxt   = r_mem_rd_addr;
    w_mem_wr_valid_nxt  = r_mem_wr_valid;
    w_mem_wr_addr_nxt   = r_mem_wr_addr;
    w_mem_wr_data_nxt   = r_mem_wr_data;
    w_cons_rd_ready_nxt = '0;
    w_cons_wr_ready_nxt = '0;
    w_cons_rd_data_nxt  = r_cons_rd_data;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt     = w_pick_idx;
          w_grant_ptr_nxt = (w_pick_idx == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                         : w_pick_idx + 1'b1;
          if (consumer_read_valid[w_pick_idx]) begin
            w_served_read_nxt  = 1'b1;
            w_mem_rd_valid_nxt = 1'b1;
            w_mem_rd_addr_nxt  = consumer_read_address[w_pick_idx];
            w_state_nxt        = ST_READ_WAIT;
          end else begin
            w_served_read_nxt  = 1'b0;
            w_mem_wr_valid_nxt = 1'b1;
            w_mem_wr_addr_nxt  = consumer_write_address[w_pick_idx];
            w_mem_wr_data_nxt  = consumer_write_data[w_pick_idx];
            w_state_nxt        = ST_WRITE_WAIT;
          end
        end
      end
      ST_READ_WAIT: begin
        if (mem_read_ready) begin
          w_mem_rd_valid_nxt          = 1'b0;
          w_cons_rd_data_nxt[r_owner]  = mem_read_data;
          w_cons_rd_ready_nxt[r_owner] = 1'b1;
          w_state_nxt                 = ST_RELAY;
        end
      end
      ST_WRITE_WAIT: begin
        if (mem_write_ready) begin
          w_mem_wr_valid_nxt          = 1'b0;
          w_cons_wr_ready_nxt[r_owner] = 1'b1;
          w_state_nxt                 = ST_RELAY;
        end
      end
      ST_RELAY: begin
        if (r_served_read ? !consumer_read_valid[r_owner] : !consumer_write_valid[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_grant_ptr     <= '0;
      r_owner         <= '0;
      r_served_read   <= 1'b0;
      r_mem_rd_valid  <= 1'b0;
      r_mem_rd_addr   <= '0;
      r_mem_wr_valid  <= 1'b0;
      r_mem_wr_addr   <= '0;
      r_mem_wr_data   <= '0;
      r_cons_rd_ready <= '0;
      r_cons_wr_ready <= '0;
      r_cons_rd_data  <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_grant_ptr     <= w_grant_ptr_nxt;
      r_owner         <= w_owner_nxt;
      r_served_read   <= w_served_read_nxt;
      r_mem_rd_valid  <= w_mem_rd_valid_nxt;
      r_mem_rd_addr   <= w_mem_rd_addr_nxt;
      r_mem_wr_valid  <= w_mem_wr_valid_nxt;
      r_mem_wr_addr   <= w_mem_wr_addr_nxt;
      r_mem_wr_data   <= w_mem_wr_data_nxt;
      r_cons_rd_ready <= w_cons_rd_ready_nxt;
      r_cons_wr_ready <= w_cons_wr_ready_nxt;
      r_cons_rd_data  <= w_cons_rd_data_nxt;
    end
  end

  assign consumer_read_ready  = r_cons_rd_ready;
  assign consumer_read_data   = r_cons_rd_data;
  assign consumer_write_ready = r_cons_wr_ready;
  assign mem_read_valid       = r_mem_rd_valid;
  assign mem_read_address     = r_mem_rd_addr;
  assign mem_write_valid      = r_mem_wr_valid;
  assign mem_write_address    = r_mem_wr_addr;
  assign mem_write_data       = r_mem_wr_data;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_data_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  localparam int PH_FREE  = 0;
  localparam int PH_MEM   = 1;
  localparam int PH_RELAY = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] rv = '0, wv = '0;
  logic [N-1:0][AW-1:0] ra = '0, wa = '0;
  logic [N-1:0][DW-1:0] wd = '0;
  logic [N-1:0] crr, cwr;
  logic [N-1:0][DW-1:0] crd;
  logic mrv, mwv;
  logic mrr = 1'b0, mwr = 1'b0;
  logic [AW-1:0] mra, mwa;
  logic [DW-1:0] mwd;
  logic [DW-1:0] mrd = '0;

  int n_checks = 0;
  int n_err = 0;

  // reference model: what the outputs must be after the most recent edge
  int m_phase = PH_FREE;
  int m_ptr = 0;
  int m_owner = 0;
  bit m_is_read = 1'b0;
  logic m_rv = 1'b0, m_wv = 1'b0;
  logic [AW-1:0] m_ra = '0, m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  logic [N-1:0] m_rrdy = '0, m_wrdy = '0;
  logic [N-1:0][DW-1:0] m_rdata = '0;

  // stimulus controls
  bit random_en = 1'b0;
  bit fixed_rd = 1'b0;
  logic [DW-1:0] fixed_rd_val = '0;
  int rd_stall = 0;
  int wr_stall = 0;
  int done_q[$];
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .NUM_CONSUMERS (N),
    .ADDR_BITS     (AW),
    .DATA_BITS     (DW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory side: ready only while the arbiter presents a request, optionally stalled.
  task automatic respond();
    mrr = 1'b0;
    mwr = 1'b0;
    mrd = fixed_rd ? fixed_rd_val : DW'($urandom);
    if (mrv === 1'b1) begin
      if (rd_stall > 0) rd_stall--;
      else if (!random_en || $urandom_range(0, 2) != 0) mrr = 1'b1;
    end
    if (mwv === 1'b1) begin
      if (wr_stall > 0) wr_stall--;
      else if (!random_en || $urandom_range(0, 2) != 0) mwr = 1'b1;
    end
  endtask

  // Advance the model across the coming edge using the inputs now being driven.
  task automatic model_step();
    if (reset) begin
      m_phase = PH_FREE; m_ptr = 0; m_owner = 0; m_is_read = 1'b0;
      m_rv = 1'b0; m_ra = '0; m_wv = 1'b0; m_wa = '0; m_wd = '0;
      m_rrdy = '0; m_wrdy = '0; m_rdata = '0;
    end else begin
      m_rrdy = '0;
      m_wrdy = '0;
      if (m_phase == PH_FREE) begin
        int start = m_ptr;
        bit found = 1'b0;
        for (int k = 0; k < N; k++) begin
          int c = (start + k) % N;
          if (!found && (rv[c] || wv[c])) begin
            found = 1'b1;
            m_owner = c;
            m_ptr = (c + 1) % N;
            m_phase = PH_MEM;
            m_is_read = rv[c];
            if (rv[c]) begin
              m_rv = 1'b1; m_ra = ra[c];
            end else begin
              m_wv = 1'b1; m_wa = wa[c]; m_wd = wd[c];
            end
          end
        end
      end else if (m_phase == PH_MEM) begin
        if (m_is_read && mrr) begin
          m_rv = 1'b0;
          m_rdata[m_owner] = mrd;
          m_rrdy[m_owner] = 1'b1;
          m_phase = PH_RELAY;
        end else if (!m_is_read && mwr) begin
          m_wv = 1'b0;
          m_wrdy[m_owner] = 1'b1;
          m_phase = PH_RELAY;
        end
      end else begin
        if (m_is_read ? !rv[m_owner] : !wv[m_owner]) m_phase = PH_FREE;
      end
    end
  endtask

  task automatic compare_all();
    check("mem_read_valid", 64'(mrv), 64'(m_rv));
    check("mem_read_address", 64'(mra), 64'(m_ra));
    check("mem_write_valid", 64'(mwv), 64'(m_wv));
    check("mem_write_address", 64'(mwa), 64'(m_wa));
    check("mem_write_data", 64'(mwd), 64'(m_wd));
    check("consumer_read_ready", 64'(crr), 64'(m_rrdy));
    check("consumer_write_ready", 64'(cwr), 64'(m_wrdy));
    check("consumer_read_data", 64'(crd), 64'(m_rdata));
  endtask

  // One clock: drive memory side, step model, sample after the edge, let agents react.
  task automatic tick();
    respond();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (mwv === 1'b1) begin
      last_wa = mwa;
      last_wd = mwd;
    end
    for (int c = 0; c < N; c++) begin
      bit jd = 1'b0;
      if (crr[c] === 1'b1) begin done_q.push_back(c); rv[c] = 1'b0; jd = 1'b1; end
      if (cwr[c] === 1'b1) begin done_q.push_back(c + N); wv[c] = 1'b0; jd = 1'b1; end
      if (random_en && !jd) begin
        if (rv[c] && $urandom_range(0, 39) == 0) rv[c] = 1'b0;
        else if (!rv[c] && $urandom_range(0, 5) == 0) begin
          rv[c] = 1'b1; ra[c] = AW'($urandom);
        end
        if (wv[c] && $urandom_range(0, 39) == 0) wv[c] = 1'b0;
        else if (!wv[c] && $urandom_range(0, 5) == 0) begin
          wv[c] = 1'b1; wa[c] = AW'($urandom); wd[c] = DW'($urandom);
        end
      end
    end
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int t = 0;
    while (done_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    check(name, 64'(done_q.size() >= n), 64'(1));
  endtask

  task automatic check_order(input string name, input int first, input int exp_a[4]);
    for (int i = 0; i < 4; i++) begin
      int act = (done_q.size() > first + i) ? done_q[first + i] : -1;
      check(name, 64'(act), 64'(exp_a[i]));
    end
  endtask

  initial begin
    int wp;
    // reset state
    reset = 1'b1;
    repeat (2) tick();
    check("rst_mem_read_valid", 64'(mrv), 64'(0));
    check("rst_mem_write_valid", 64'(mwv), 64'(0));
    check("rst_consumer_readies", 64'({crr, cwr}), 64'(0));
    check("rst_consumer_read_data", 64'(crd), 64'(0));
    reset = 1'b0;
    tick();

    // single read, minimum latency, ch2 addr 0x10 -> 0x5A
    done_q.delete();
    fixed_rd = 1'b1; fixed_rd_val = 8'h5A;
    rv[2] = 1'b1; ra[2] = 8'h10;
    tick();
    check("t1_mem_read_valid", 64'(mrv), 64'(1));
    check("t1_mem_read_address", 64'(mra), 64'(8'h10));
    check("t1_no_early_ready", 64'(crr), 64'(0));
    tick();
    check("t1_read_ready", 64'(crr), 64'(4'b0100));
    check("t1_read_data", 64'(crd[2]), 64'(8'h5A));
    tick();
    check("t1_ready_one_cycle", 64'(crr), 64'(0));
    repeat (3) tick();
    check("t1_served_once", 64'(done_q.size()), 64'(1));
    check("t1_data_held", 64'(crd[2]), 64'(8'h5A));
    fixed_rd = 1'b0;

    // after ch2 the pointer sits at 3
    done_q.delete();
    for (int c = 0; c < N; c++) begin rv[c] = 1'b1; ra[c] = AW'(8'h30 + c); end
    wait_done(4, 40, "t2_all_served");
    check_order("t2_order_from_3", 0, '{3, 0, 1, 2});
    repeat (2) tick();

    // ch0 alone moves pointer to 1, then contention serves 1,2,3,0
    done_q.delete();
    rv[0] = 1'b1; ra[0] = 8'h01;
    wait_done(1, 20, "t3_ch0_served");
    repeat (2) tick();
    for (int c = 0; c < N; c++) begin rv[c] = 1'b1; ra[c] = AW'(8'h40 + c); end
    wait_done(5, 40, "t3_all_served");
    check_order("t3_order_from_1", 1, '{1, 2, 3, 0});
    repeat (2) tick();

    // read beats write on the same channel
    done_q.delete();
    rv[1] = 1'b1; ra[1] = 8'h20;
    wv[1] = 1'b1; wa[1] = 8'h21; wd[1] = 8'h7F;
    wait_done(2, 30, "t4_both_served");
    check("t4_read_first", 64'(done_q[0]), 64'(1));
    check("t4_write_second", 64'(done_q[1]), 64'(1 + N));
    check("t4_write_address", 64'(last_wa), 64'(8'h21));
    check("t4_write_data", 64'(last_wd), 64'(8'h7F));
    repeat (2) tick();

    // memory stall for 5 cycles
    rd_stall = 5;
    rv[0] = 1'b1; ra[0] = 8'h44;
    tick();
    check("t5_valid_issued", 64'(mrv), 64'(1));
    repeat (5) begin
      tick();
      check("t5_stall_valid", 64'(mrv), 64'(1));
      check("t5_stall_address", 64'(mra), 64'(8'h44));
      check("t5_stall_no_ready", 64'(crr), 64'(0));
    end
    tick();
    check("t5_ready_after_release", 64'(crr), 64'(4'b0001));
    repeat (3) tick();

    // reset while a write is stalled at the memory
    wr_stall = 10;
    wv[3] = 1'b1; wa[3] = 8'h55; wd[3] = 8'h66;
    tick();
    check("t6_write_issued", 64'(mwv), 64'(1));
    tick();
    check("t6_write_waiting", 64'(mwv), 64'(1));
    reset = 1'b1;
    tick();
    check("t6_rst_write_valid", 64'(mwv), 64'(0));
    check("t6_rst_write_addr_data", 64'({mwa, mwd}), 64'(0));
    check("t6_rst_read_side", 64'({mrv, mra}), 64'(0));
    check("t6_rst_readies_data", 64'({crr, cwr, crd}), 64'(0));
    reset = 1'b0; wv[3] = 1'b0; wr_stall = 0;
    wp = 0;
    repeat (6) begin
      tick();
      if (cwr !== '0) wp++;
    end
    check("t6_no_write_ready", 64'(wp), 64'(0));

    // ch3 twice wraps pointer to 0 each time
    done_q.delete();
    rv[3] = 1'b1; ra[3] = 8'h77;
    wait_done(1, 20, "t7_first_ch3");
    repeat (2) tick();
    rv[3] = 1'b1; ra[3] = 8'h78;
    wait_done(2, 20, "t7_second_ch3");
    repeat (2) tick();
    for (int c = 0; c < N; c++) begin rv[c] = 1'b1; ra[c] = AW'(8'h60 + c); end
    wait_done(6, 40, "t7_all_served");
    check_order("t7_order_from_0", 2, '{0, 1, 2, 3});
    repeat (2) tick();

    // randomized traffic against the model
    random_en = 1'b1;
    repeat (3000) begin
      tick();
      if (done_q.size() > 64) done_q.delete();
    end
    random_en = 1'b0;
    rv = '0;
    wv = '0;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, the number of LSU request channels sharing one data memory port.
REQ-002 SHALL have parameter ADDR_BITS, default 8, the data memory address width.
REQ-003 SHALL have parameter DATA_BITS, default 8, the data memory data width.
REQ-004 clk  input  1  the only clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 consumer_read_valid  input  [NUM_CONSUMERS]  per-channel read request.
REQ-007 consumer_read_address  input  [NUM_CONSUMERS][ADDR_BITS]  per-channel read address.
REQ-008 consumer_read_ready  output  [NUM_CONSUMERS]  per-channel read completion, one-cycle pulse.
REQ-009 consumer_read_data  output  [NUM_CONSUMERS][DATA_BITS]  per-channel returned read data.
REQ-010 consumer_write_valid / consumer_write_address / consumer_write_data  input  [NUM_CONSUMERS] / [NUM_CONSUMERS][ADDR_BITS] / [NUM_CONSUMERS][DATA_BITS]  per-channel write request.
REQ-011 consumer_write_ready  output  [NUM_CONSUMERS]  per-channel write completion, one-cycle pulse.
REQ-012 mem_read_valid, mem_read_address  output  1, ADDR_BITS;  mem_read_ready, mem_read_data  input  1, DATA_BITS.
REQ-013 mem_write_valid, mem_write_address, mem_write_data  output  1, ADDR_BITS, DATA_BITS;  mem_write_ready  input  1.

Function
REQ-014 SHALL run an FSM with states IDLE, READ_WAIT, WRITE_WAIT, RELAY; at most one memory transaction in flight.
REQ-015 IDLE: scan channels round-robin starting at grant_ptr; first channel with read_valid or write_valid wins; read beats write within a channel.
REQ-016 On a winning read: next edge registers mem_read_valid=1 and the address, latches owner index, state -> READ_WAIT; write analogously -> WRITE_WAIT.
REQ-017 On every grant, grant_ptr <= (owner+1) mod NUM_CONSUMERS, wrapping NUM_CONSUMERS-1 -> 0.
REQ-018 Memory-side valid, address and data SHALL stay stable until the cycle the matching mem_*_ready is sampled high.
REQ-019 READ_WAIT with mem_read_ready=1: next edge mem_read_valid=0, consumer_read_data[owner]=mem_read_data, consumer_read_ready[owner]=1, state -> RELAY.
REQ-020 WRITE_WAIT with mem_write_ready=1: next edge mem_write_valid=0, consumer_write_ready[owner]=1, state -> RELAY.
REQ-021 RELAY: consumer_*_ready SHALL drop after exactly one cycle; state -> IDLE once owner's request valid of the served kind is low, else hold in RELAY with ready low.
REQ-022 consumer_read_data[owner] SHALL hold its value until the next read completion for that channel.
REQ-023 Minimum latency: consumer valid sampled at edge n, mem valid at n+1, consumer ready at n+2 if memory ready is combinationally high.
REQ-024 Owner dropping valid during READ_WAIT/WRITE_WAIT: memory transaction SHALL still complete; ready pulse still issued.
REQ-025 No request pending: remain in IDLE, all valids and readies low, grant_ptr unchanged.
REQ-026 Only the owner channel SHALL ever see a ready pulse; at most one consumer ready bit high per cycle.

Reset
REQ-027 Reset SHALL force state IDLE, grant_ptr 0, all mem_*_valid and consumer_*_ready 0, all address/data outputs 0.
REQ-028 Reset asserted mid-transaction SHALL abandon it; no ready pulse issued afterwards for it.

Structure
REQ-029 Shared package SHALL hold the FSM state enum (arbiter_state_t) and default width constants.
REQ-030 One sub-module, rr_picker (combinational round-robin index selector from request mask and grant_ptr), is natural; all else in data_mem_arbiter.

Verification
REQ-031 Single read: ch2 reads addr 0x10, memory returns 0x5A one cycle later -> consumer_read_ready[2] pulses once, data 0x5A, grant_ptr=3.
REQ-032 Contention: ch0-ch3 read simultaneously, grant_ptr=1 -> service order 1,2,3,0.
REQ-033 Read+write same channel: ch1 read 0x20 and write 0x21=0x7F -> read served first, write next grant cycle.
REQ-034 Memory stall: mem_read_ready low 5 cycles -> mem_read_valid/address stable throughout, ready pulse after release.
REQ-035 Reset during WRITE_WAIT -> next edge all outputs 0, state IDLE, no consumer_write_ready pulse.
REQ-036 Wrap: only ch3 requests twice -> grant_ptr 0 after each, both served.
